// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : pmem_responder
// Description : Handshaked multi-cycle memory responder with an internal
//               64-bit word array, byte-masked writes and range checking.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int c_idx_w  = $clog2(DEPTH_WORDS);
    localparam bit c_single = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_cnt;
    logic         r_wen;
    logic [60:0]  r_addr_hi;
    logic [63:0]  r_wdata;
    logic [7:0]   r_wmask;
    logic [63:0]  r_resp_rdata;
    logic         r_resp_err;
    logic [63:0]  r_mem [DEPTH_WORDS];

    logic               w_accept;
    logic               w_acc_wen;
    logic [60:0]        w_acc_addr_hi;
    logic [63:0]        w_acc_wdata;
    logic [7:0]         w_acc_wmask;
    logic [60:0]        w_off;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;
    logic               w_do_access;

    // Byte offset within a word never affects the access.
    wire w_unused_addr_lsbs = &{1'b0, req_addr[2:0]};

    assign req_ready  = rst_n && (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign w_accept   = req_valid && req_ready;

    // With single-cycle latency the access uses the live request fields.
    assign w_acc_wen     = (r_state == ST_IDLE) ? req_wen         : r_wen;
    assign w_acc_addr_hi = (r_state == ST_IDLE) ? req_addr[63:3]  : r_addr_hi;
    assign w_acc_wdata   = (r_state == ST_IDLE) ? req_wdata       : r_wdata;
    assign w_acc_wmask   = (r_state == ST_IDLE) ? req_wmask       : r_wmask;

    // Word-granular compare avoids overflow of BASE_ADDR + span.
    assign w_off      = w_acc_addr_hi - BASE_ADDR[63:3];
    assign w_in_range = (w_acc_addr_hi >= BASE_ADDR[63:3]) &&
                        (w_off < 61'(DEPTH_WORDS));
    assign w_idx      = w_off[c_idx_w-1:0];

    assign w_do_access = rst_n &&
        (((r_state == ST_IDLE) && w_accept && c_single) ||
         ((r_state == ST_WAIT) && (r_cnt == 4'd1)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = c_single ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wen     <= req_wen;
                r_addr_hi <= req_addr[63:3];
                r_wdata   <= req_wdata;
                r_wmask   <= req_wmask;
                if (!c_single) r_cnt <= 4'(LATENCY - 1);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_do_access) begin
                r_resp_rdata <= (w_in_range && !w_acc_wen) ? r_mem[w_idx] : 64'd0;
                r_resp_err   <= !w_in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_access && w_in_range && w_acc_wen) begin
            for (int i = 0; i < 8; i++) begin
                if (w_acc_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmem_responder
// Description : Directed self-checking bench for pmem_responder (LATENCY 2 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmem_responder;

    logic        clk;
    logic        rst_n;

    logic        a_req_valid, a_req_ready, a_req_wen, a_resp_valid, a_resp_ready, a_resp_err;
    logic [63:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [7:0]  a_req_wmask;

    logic        b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_ready, b_resp_err;
    logic [63:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [7:0]  b_req_wmask;

    int n_tests;
    int n_fail;

    pmem_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_wen    (a_req_wen),
        .req_addr   (a_req_addr),
        .req_wdata  (a_req_wdata),
        .req_wmask  (a_req_wmask),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_rdata (a_resp_rdata),
        .resp_err   (a_resp_err)
    );

    pmem_responder #(.BASE_ADDR(64'h8000_0000), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_wen    (b_req_wen),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .req_wmask  (b_req_wmask),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_rdata (b_resp_rdata),
        .resp_err   (b_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full transaction on DUT a; lat = edges from acceptance to resp_valid (-1 if never accepted).
    task automatic txn(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [7:0] wm, output logic [63:0] rd, output logic er,
                       output int lat);
        int guard;
        a_req_valid = 1'b1; a_req_wen = wen; a_req_addr = addr;
        a_req_wdata = wd;   a_req_wmask = wm;
        guard = 0;
        while (!a_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        if (guard >= 20) begin
            a_req_valid = 1'b0; rd = 'x; er = 1'bx; lat = -1;
        end else begin
            @(posedge clk); #1;
            a_req_valid = 1'b0;
            lat = 0;
            while (!a_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            rd = a_resp_rdata; er = a_resp_err;
            a_resp_ready = 1'b1;
            @(posedge clk); #1;
            a_resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_low: got %b want 0", a_req_ready); end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_resp_rdata !== 64'd0 || a_resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                     a_req_ready, a_resp_valid, a_resp_rdata, a_resp_err);
        end
    endtask

    task automatic test_write_read();
        logic [63:0] rd; logic er; int lat;
        txn(1'b1, 64'h8000_0000, 64'h1122334455667788, 8'hFF, rd, er, lat);
        n_tests++;
        if (rd !== 64'd0 || er !== 1'b0 || lat !== 1) begin
            n_fail++; $display("FAIL write_word0: got rdata=%h err=%b lat=%0d want 0 0 1", rd, er, lat);
        end
        txn(1'b0, 64'h8000_0000, 64'd0, 8'h00, rd, er, lat);
        n_tests++;
        if (rd !== 64'h1122334455667788 || er !== 1'b0 || lat !== 1) begin
            n_fail++; $display("FAIL read_word0: got rdata=%h err=%b lat=%0d want 1122334455667788 0 1", rd, er, lat);
        end
    endtask

    task automatic test_partial_write();
        logic [63:0] rd; logic er; int lat;
        txn(1'b1, 64'h8000_0008, 64'h1122334455667788, 8'hFF, rd, er, lat);
        txn(1'b1, 64'h8000_0008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, rd, er, lat);
        txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, rd, er, lat);
        n_tests++;
        if (rd !== 64'h11223344AAAAAAAA || er !== 1'b0) begin
            n_fail++; $display("FAIL partial_merge: got rdata=%h err=%b want 11223344aaaaaaaa 0", rd, er);
        end
        txn(1'b0, 64'h8000_000D, 64'd0, 8'h00, rd, er, lat);
        n_tests++;
        if (rd !== 64'h11223344AAAAAAAA) begin
            n_fail++; $display("FAIL read_ignores_lsbs: got %h want 11223344aaaaaaaa", rd);
        end
        txn(1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rd, er, lat);
        txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, rd, er, lat);
        n_tests++;
        if (rd !== 64'h11223344AAAAAAAA || er !== 1'b0) begin
            n_fail++; $display("FAIL zero_mask_noop: got rdata=%h err=%b want 11223344aaaaaaaa 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        int guard; int bad;
        a_req_valid = 1'b1; a_req_wen = 1'b0; a_req_addr = 64'h8000_0000;
        a_req_wdata = 64'd0; a_req_wmask = 8'h00;
        @(posedge clk); #1;
        a_req_addr = 64'h8000_0008;  // next request held pending
        guard = 0;
        while (!a_resp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (a_resp_valid !== 1'b1 || a_resp_rdata !== 64'h1122334455667788 || a_req_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (bad != 0 || guard >= 20) begin
            n_fail++; $display("FAIL backpressure_hold: got %0d bad cycles (timeout=%0d) valid=%b rdata=%h ready=%b want 0 bad cycles",
                               bad, guard >= 20, a_resp_valid, a_resp_rdata, a_req_ready);
        end
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        n_tests++;
        if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL backpressure_release: got valid=%b ready=%b want 0 1", a_resp_valid, a_req_ready);
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        n_tests++;
        if (a_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL pending_accepted: got ready=%b want 0", a_req_ready);
        end
        guard = 0;
        while (!a_resp_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        n_tests++;
        if (a_resp_rdata !== 64'h11223344AAAAAAAA || guard !== 1) begin
            n_fail++; $display("FAIL pending_read: got rdata=%h lat=%0d want 11223344aaaaaaaa 1", a_resp_rdata, guard);
        end
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; logic er; int lat;
        txn(1'b1, 64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, rd, er, lat);
        n_tests++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            n_fail++; $display("FAIL oor_below: got err=%b rdata=%h want 1 0", er, rd);
        end
        txn(1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, rd, er, lat);
        n_tests++;
        if (er !== 1'b1 || rd !== 64'd0) begin
            n_fail++; $display("FAIL oor_end: got err=%b rdata=%h want 1 0", er, rd);
        end
        txn(1'b1, 64'h8000_1FF8, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, rd, er, lat);
        txn(1'b0, 64'h8000_1FF8, 64'd0, 8'h00, rd, er, lat);
        n_tests++;
        if (er !== 1'b0 || rd !== 64'h0F0E_0D0C_0B0A_0908) begin
            n_fail++; $display("FAIL last_word: got err=%b rdata=%h want 0 0f0e0d0c0b0a0908", er, rd);
        end
        txn(1'b0, 64'h8000_0000, 64'd0, 8'h00, rd, er, lat);
        n_tests++;
        if (er !== 1'b0 || rd !== 64'h1122334455667788) begin
            n_fail++; $display("FAIL oor_no_corrupt: got err=%b rdata=%h want 0 1122334455667788", er, rd);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] rd; logic er; int lat;
        txn(1'b1, 64'h8000_0018, 64'h0303_0303_0303_0303, 8'hFF, rd, er, lat);
        a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_addr = 64'h8000_0018;
        a_req_wdata = 64'hCAFE_CAFE_CAFE_CAFE; a_req_wmask = 8'hFF;
        @(posedge clk); #1;          // accepted, now waiting
        a_req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;          // would-be commit edge
        n_tests++;
        if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_no_resp: got valid=%b ready=%b want 0 0", a_resp_valid, a_req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_resp_rdata !== 64'd0 || a_resp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                               a_req_ready, a_resp_valid, a_resp_rdata, a_resp_err);
        end
        @(posedge clk); #1;
        txn(1'b0, 64'h8000_0018, 64'd0, 8'h00, rd, er, lat);
        n_tests++;
        if (rd !== 64'h0303_0303_0303_0303 || er !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_no_commit: got rdata=%h err=%b want 0303030303030303 0", rd, er);
        end
    endtask

    task automatic test_back_to_back_lat1();
        logic exp_v;
        n_tests++;
        if (b_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL lat1_idle_ready: got %b want 1", b_req_ready);
        end
        b_req_valid = 1'b1; b_req_wen = 1'b1; b_req_addr = 64'h8000_0028;
        b_req_wdata = 64'h0123_4567_89AB_CDEF; b_req_wmask = 8'hFF;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp_v = (k % 2) == 1;
            n_tests++;
            if (b_resp_valid !== exp_v || b_req_ready !== !exp_v) begin
                n_fail++; $display("FAIL lat1_alternate_%0d: got valid=%b ready=%b want %b %b",
                                   k, b_resp_valid, b_req_ready, exp_v, !exp_v);
            end
            if (k == 1) begin
                n_tests++;
                if (b_resp_rdata !== 64'd0 || b_resp_err !== 1'b0) begin
                    n_fail++; $display("FAIL lat1_write_resp: got rdata=%h err=%b want 0 0", b_resp_rdata, b_resp_err);
                end
                b_req_wen = 1'b0;
            end else if (k == 3 || k == 5) begin
                n_tests++;
                if (b_resp_rdata !== 64'h0123_4567_89AB_CDEF || b_resp_err !== 1'b0) begin
                    n_fail++; $display("FAIL lat1_read_%0d: got rdata=%h err=%b want 0123456789abcdef 0",
                                       k, b_resp_rdata, b_resp_err);
                end
            end
        end
        b_req_valid = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_wen = 1'b0; a_req_addr = 64'd0;
        a_req_wdata = 64'd0; a_req_wmask = 8'd0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = 64'd0;
        b_req_wdata = 64'd0; b_req_wmask = 8'd0; b_resp_ready = 1'b1;
        #1;
        test_reset();
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_write();
        test_back_to_back_lat1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
